// File: rtl/mem_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stream_loader
//  Purpose  : Byte-stream memory programmer for the noobs CPU system. Decodes
//             load commands from a valid/ready byte stream, writes payload
//             bytes into imem or dmem, and releases the CPU from reset after
//             a fixed cool-off once the GO command arrives.
//  Ports    : clk, reset_ (sync, active-low)
//             s_data/s_valid/s_ready        - input byte stream
//             i_addr/i_wr_data/i_wr         - imem write port
//             d_addr/d_wr_data/d_wr         - dmem write port
//             cpu_reset_                    - active-low CPU reset
//             busy                          - load frame in progress
//             err                           - sticky protocol error
//  Options  : MEM_LOADER_CHECKSUM_EN adds a trailing checksum byte to every
//             load frame with LEN > 0 (sum of payload + checksum == 0 mod 256)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stream_loader #(
    parameter int ADDR_W   = 12,
    parameter int COOL_OFF = 32
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] i_addr,
    output logic [7:0]        i_wr_data,
    output logic              i_wr,
    output logic [ADDR_W-1:0] d_addr,
    output logic [7:0]        d_wr_data,
    output logic              d_wr,
    output logic              cpu_reset_,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = (COOL_OFF < 2) ? 1 : $clog2(COOL_OFF + 1);

    localparam logic [7:0] C_CMD_I = 8'h49;
    localparam logic [7:0] C_CMD_D = 8'h44;
    localparam logic [7:0] C_CMD_G = 8'h47;
    localparam logic [7:0] C_CMD_R = 8'h52;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_ADDR_HI = 4'd1;
    localparam logic [3:0] S_ADDR_LO = 4'd2;
    localparam logic [3:0] S_LEN_HI  = 4'd3;
    localparam logic [3:0] S_LEN_LO  = 4'd4;
    localparam logic [3:0] S_DATA    = 4'd5;
`ifdef MEM_LOADER_CHECKSUM_EN
    localparam logic [3:0] S_CSUM    = 4'd6;
`endif
    localparam logic [3:0] S_COOL    = 4'd7;
    localparam logic [3:0] S_RUN     = 4'd8;

    logic [3:0]        r_state;
    logic              r_alive;      // low only in the cycle(s) directly after reset
    logic              r_sel_d;      // 1 = frame targets dmem
    logic [3:0]        r_addr_hi;
    logic [3:0]        r_len_hi;
    logic [ADDR_W-1:0] r_ptr;
    logic [11:0]       r_rem;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_i_addr;
    logic [7:0]        r_i_data;
    logic              r_i_wr;
    logic [ADDR_W-1:0] r_d_addr;
    logic [7:0]        r_d_data;
    logic              r_d_wr;
    logic              r_cpu_rst_n;
    logic              r_err;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_sum;
    logic [7:0]        w_csum;
`endif

    logic              w_xfer;
    logic [11:0]       w_len;
    logic [ADDR_W-1:0] w_addr;

    assign s_ready = r_alive && (r_state != S_COOL);
    assign w_xfer  = s_valid && s_ready;
    assign w_len   = {r_len_hi, s_data};
    // Frame address is always 12 bits on the wire; fit it to the port width.
    assign w_addr  = ADDR_W'({r_addr_hi, s_data});
`ifdef MEM_LOADER_CHECKSUM_EN
    assign w_csum  = r_sum + s_data;
`endif

    always_ff @(posedge clk) begin
        if (!reset_) begin
            r_state     <= S_IDLE;
            r_alive     <= 1'b0;
            r_sel_d     <= 1'b0;
            r_addr_hi   <= '0;
            r_len_hi    <= '0;
            r_ptr       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_i_addr    <= '0;
            r_i_data    <= '0;
            r_i_wr      <= 1'b0;
            r_d_addr    <= '0;
            r_d_data    <= '0;
            r_d_wr      <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_err       <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_alive <= 1'b1;
            // Strobes are single-cycle pulses; only DATA re-arms them.
            r_i_wr  <= 1'b0;
            r_d_wr  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        case (s_data)
                            C_CMD_I: begin
                                r_sel_d <= 1'b0;
                                r_state <= S_ADDR_HI;
                            end
                            C_CMD_D: begin
                                r_sel_d <= 1'b1;
                                r_state <= S_ADDR_HI;
                            end
                            C_CMD_G: begin
                                r_cnt   <= CNT_W'(COOL_OFF);
                                r_state <= S_COOL;
                            end
                            C_CMD_R: ;  // CPU already held in reset
                            default: r_err <= 1'b1;
                        endcase
                    end
                end

                S_ADDR_HI: begin
                    if (w_xfer) begin
                        r_addr_hi <= s_data[3:0];
                        r_state   <= S_ADDR_LO;
                    end
                end

                S_ADDR_LO: begin
                    if (w_xfer) begin
                        r_ptr   <= w_addr;
                        r_state <= S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= s_data[3:0];
                        r_state  <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_rem <= w_len;
`ifdef MEM_LOADER_CHECKSUM_EN
                        r_sum <= '0;
`endif
                        // Empty frames carry no payload and no checksum.
                        r_state <= (w_len == 12'd0) ? S_IDLE : S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_xfer) begin
                        if (r_sel_d) begin
                            r_d_addr <= r_ptr;
                            r_d_data <= s_data;
                            r_d_wr   <= 1'b1;
                        end else begin
                            r_i_addr <= r_ptr;
                            r_i_data <= s_data;
                            r_i_wr   <= 1'b1;
                        end
                        r_ptr <= r_ptr + ADDR_W'(1);
                        r_rem <= r_rem - 12'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
                        r_sum <= w_csum;
                        if (r_rem == 12'd1) begin
                            r_state <= S_CSUM;
                        end
`else
                        if (r_rem == 12'd1) begin
                            r_state <= S_IDLE;
                        end
`endif
                    end
                end

`ifdef MEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_xfer) begin
                        // Writes already issued stay in memory; only flag it.
                        if (w_csum != 8'h00) begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                end
`endif

                S_COOL: begin
                    if (r_cnt == '0) begin
                        r_cpu_rst_n <= 1'b1;
                        r_state     <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                S_RUN: begin
                    if (w_xfer) begin
                        if (s_data == C_CMD_R) begin
                            r_cpu_rst_n <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i_addr     = r_i_addr;
    assign i_wr_data  = r_i_data;
    assign i_wr       = r_i_wr;
    assign d_addr     = r_d_addr;
    assign d_wr_data  = r_d_data;
    assign d_wr       = r_d_wr;
    assign cpu_reset_ = r_cpu_rst_n;
    assign err        = r_err;
`ifdef MEM_LOADER_CHECKSUM_EN
    assign busy = (r_state == S_ADDR_HI) || (r_state == S_ADDR_LO) ||
                  (r_state == S_LEN_HI)  || (r_state == S_LEN_LO)  ||
                  (r_state == S_DATA)    || (r_state == S_CSUM);
`else
    assign busy = (r_state == S_ADDR_HI) || (r_state == S_ADDR_LO) ||
                  (r_state == S_LEN_HI)  || (r_state == S_LEN_LO)  ||
                  (r_state == S_DATA);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stream_loader
//  Purpose  : Self-checking bench for mem_stream_loader. Stimulus pushes the
//             expected memory writes into a scoreboard queue; an independent
//             monitor pops and compares whenever a write strobe appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stream_loader;

    localparam int AW = 12;
    localparam int CO = 4;

    logic          clk;
    logic          reset_;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] i_addr;
    logic [7:0]    i_wr_data;
    logic          i_wr;
    logic [AW-1:0] d_addr;
    logic [7:0]    d_wr_data;
    logic          d_wr;
    logic          cpu_reset_;
    logic          busy;
    logic          err;

    mem_stream_loader #(.ADDR_W(AW), .COOL_OFF(CO)) u_dut (
        .clk        (clk),
        .reset_     (reset_),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .i_addr     (i_addr),
        .i_wr_data  (i_wr_data),
        .i_wr       (i_wr),
        .d_addr     (d_addr),
        .d_wr_data  (d_wr_data),
        .d_wr       (d_wr),
        .cpu_reset_ (cpu_reset_),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        dmem;
        logic [11:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] pl_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic       m_err  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected write, in time too.
    always @(negedge clk) begin
        if (i_wr || d_wr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {30'd0, i_wr, d_wr}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_strobe_sel", {30'd0, i_wr, d_wr}, mon_e.dmem ? 32'd1 : 32'd2);
                chk("wr_addr", mon_e.dmem ? d_addr : i_addr, mon_e.addr);
                chk("wr_data", mon_e.dmem ? d_wr_data : i_wr_data, mon_e.data);
                chk("wr_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte and hold it until accepted; acc = accepting edge index.
    task automatic send(input logic [7:0] b, output int acc);
        int w;
        w = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!s_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            s_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc     = cyc;
        s_valid = 1'b0;
    endtask

    // Send one load frame carrying pl_q as payload. gap<0 means random bubbles.
    task automatic load_frame(input logic dm, input logic [11:0] addr, input logic [3:0] junk,
                              input int gap, input logic bad_cs);
        int         a;
        int         len;
        logic [7:0] sum;
        logic [7:0] cs;
        wr_t        e;
        len = pl_q.size();
        sum = 8'h00;
        send(dm ? 8'h44 : 8'h49, a);
        send({junk, addr[11:8]}, a);
        send(addr[7:0], a);
        send({junk, 4'(len >> 8)}, a);
        send(8'(len), a);
        for (int i = 0; i < len; i++) begin
            idle(gap < 0 ? int'($urandom_range(0, 3)) : gap);
            send(pl_q[i], a);
            e.dmem = dm;
            e.addr = 12'((int'(addr) + i) % 4096);
            e.data = pl_q[i];
            e.cyc  = a;
            exp_q.push_back(e);
            sum = sum + pl_q[i];
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        if (len > 0) begin
            cs = 8'h00 - sum;
            if (bad_cs) begin
                cs = cs + 8'h01;
                m_err = 1'b1;
            end
            send(cs, a);
        end
`else
        cs = bad_cs ? sum : 8'h00;
`endif
        idle(1);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);
        chk("err_after_frame", {31'd0, err}, {31'd0, m_err});
    endtask

    task automatic do_reset(input int n);
        reset_  = 1'b0;
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            idle(1);
            chk("rst_cpu_reset_", {31'd0, cpu_reset_}, 32'd0);
            chk("rst_strobes", {30'd0, i_wr, d_wr}, 32'd0);
            chk("rst_err", {31'd0, err}, 32'd0);
            chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        m_err = 1'b0;
        exp_q.delete();
        reset_ = 1'b1;
        idle(1);
        chk("ready_after_release", {31'd0, s_ready}, 32'd1);
    endtask

    task automatic go_and_wait();
        int a;
        send(8'h47, a);
        chk("cool_s_ready", {31'd0, s_ready}, 32'd0);
        chk("cool_cpu_reset_", {31'd0, cpu_reset_}, 32'd0);
        idle(CO - 1);
        chk("cool_before_end", {31'd0, cpu_reset_}, 32'd0);
        idle(1);
        chk("cool_last_cycle", {31'd0, cpu_reset_}, 32'd0);
        idle(1);
        chk("cpu_released", {31'd0, cpu_reset_}, 32'd1);
        chk("run_s_ready", {31'd0, s_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a;
        logic [7:0] g;
        s_data  = 8'h00;
        s_valid = 1'b0;
        reset_  = 1'b0;
        #1;
        do_reset(3);

        // Imem load at full rate.
        pl_q = '{8'hAA, 8'hBB, 8'hCC};
        load_frame(1'b0, 12'h010, 4'h0, 0, 1'b0);

        // Dmem load with bubbles, wrapping past the top address.
        pl_q = '{8'h11, 8'h22};
        load_frame(1'b1, 12'hFFF, 4'h0, 2, 1'b0);

        // Zero-length frame, junk in upper nibbles.
        pl_q.delete();
        load_frame(1'b1, 12'h123, 4'hA, 0, 1'b0);

        // Reset in the middle of a frame abandons it.
        send(8'h49, a); send(8'h00, a); send(8'h20, a); send(8'h00, a); send(8'h05, a);
        pl_q = '{8'h5A, 8'hA5};
        for (int i = 0; i < 2; i++) begin
            send(pl_q[i], a);
            exp_q.push_back('{1'b0, 12'(12'h020 + i), pl_q[i], a});
        end
        do_reset(2);
        chk("busy_after_abort", {31'd0, busy}, 32'd0);

`ifdef MEM_LOADER_CHECKSUM_EN
        pl_q = '{8'h01, 8'h02};
        load_frame(1'b0, 12'h000, 4'h0, 0, 1'b0);
        pl_q = '{8'h01, 8'h02};
        load_frame(1'b0, 12'h000, 4'h0, 0, 1'b1);
        do_reset(1);
`endif

        // GO, cool-off, then halt.
        go_and_wait();
        send(8'h52, a);
        chk("halt_cpu_reset_", {31'd0, cpu_reset_}, 32'd0);
        chk("halt_busy", {31'd0, busy}, 32'd0);
        send(8'h52, a);
        chk("r_in_idle", {31'd0, cpu_reset_}, 32'd0);
        chk("r_in_idle_err", {31'd0, err}, 32'd0);

        // Protocol errors.
        send(8'h7E, a);
        m_err = 1'b1;
        chk("bad_cmd_err", {31'd0, err}, 32'd1);
        pl_q = '{8'h33, 8'h44};
        load_frame(1'b0, 12'h400, 4'h0, 0, 1'b0);
        go_and_wait();
        send(8'h49, a);
        idle(1);
        chk("run_bad_err", {31'd0, err}, 32'd1);
        chk("run_bad_cpu", {31'd0, cpu_reset_}, 32'd1);
        send(8'h52, a);
        chk("halt2_cpu_reset_", {31'd0, cpu_reset_}, 32'd0);

        // Randomized frames and stray command bytes.
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                do begin
                    g = 8'($urandom);
                end while (g == 8'h49 || g == 8'h44 || g == 8'h47 || g == 8'h52);
                send(g, a);
                m_err = 1'b1;
                idle(1);
                chk("rand_bad_cmd_err", {31'd0, err}, 32'd1);
            end else begin
                pl_q.delete();
                for (int i = 0; i < int'($urandom_range(0, 6)); i++) begin
                    pl_q.push_back(8'($urandom));
                end
                load_frame(1'($urandom), 12'($urandom), 4'($urandom), -1,
                           ($urandom_range(0, 3) == 0));
            end
        end

        idle(4);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stream_loader.md
Name: mem_stream_loader

Overview:
- Hardware replacement for file-driven memory programming: consumes a byte stream over a valid/ready handshake.
- Decodes load commands and writes payload bytes into instruction or data memory through their write ports.
- Sequences the CPU out of reset after a fixed cool-off.
- Sits between the host/byte source and the imem/dmem/CPU reset of the noobs CPU system.

Parameters:
- ADDR_W, 12, memory address width
- COOL_OFF, 32, cycles between accepting the GO command and deasserting cpu_reset_ (min 1)

Ports:
- clk  input  1  system clock
- reset_  input  1  synchronous active-low reset
- s_data  input  8  stream byte
- s_valid  input  1  stream byte valid
- s_ready  output  1  loader accepts the byte this cycle
- i_addr  output  ADDR_W  imem write address
- i_wr_data  output  8  imem write data
- i_wr  output  1  imem write strobe, one cycle per byte
- d_addr  output  ADDR_W  dmem write address
- d_wr_data  output  8  dmem write data
- d_wr  output  1  dmem write strobe
- cpu_reset_  output  1  active-low CPU reset
- busy  output  1  a load frame is in progress
- err  output  1  sticky protocol error

Behaviour:
- Clock and reset: one clock `clk`; reset `reset_` is synchronous and active-low. All state changes on posedge clk.
- Reset values (reset_ low at posedge):
  - state=IDLE.
  - All write strobes, addresses and data = 0.
  - cpu_reset_=0, s_ready=0, busy=0, err=0.
- Reset mid-frame aborts the frame. No write is issued on the cycle after reset.
- Handshake:
  - A byte transfers when s_valid & s_ready at posedge.
  - s_ready=1 in every state except COOL and except the reset cycle.
- Commands, accepted in IDLE:
  - 0x49 'I' → load imem.
  - 0x44 'D' → load dmem.
  - 0x47 'G' → go.
  - 0x52 'R' → halt.
  - Any other byte sets err and stays in IDLE.
- Load frame sequence: cmd, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then LEN payload bytes.
  - Address is ADDR_HI[3:0]:ADDR_LO; upper bits are ignored.
  - LEN is LEN_HI[3:0]:LEN_LO.
  - LEN=0 returns to IDLE directly after LEN_LO.
- States: IDLE → ADDR_HI → ADDR_LO → LEN_HI → LEN_LO → DATA (→ CSUM when enabled) → IDLE.
  - busy=1 in ADDR_HI through CSUM.
- Writes:
  - Payload byte accepted in cycle N → *_wr=1 in cycle N+1, with *_addr and *_wr_data registered.
  - Only the selected memory's strobe pulses.
  - Address increments by 1 per byte and wraps 0xFFF→0x000.
  - Back-to-back bytes give back-to-back strobes.
  - Gaps in s_valid give no strobe.
- Remaining count: decrements per accepted payload byte; reaching 0 ends DATA.
- GO ('G') in IDLE:
  - Enters COOL and loads a counter with COOL_OFF.
  - Counter decrements each cycle; at 0, cpu_reset_ goes 1 and state goes to RUN.
  - GO to cpu_reset_ high is exactly COOL_OFF+1 cycles after the accepting edge.
- RUN:
  - cpu_reset_ stays 1 and s_ready=1.
  - 'R' drives cpu_reset_=0 on the next cycle and returns to IDLE.
  - Any other byte sets err and is dropped.
- 'R' in IDLE: no effect; cpu_reset_ stays 0.
- 'G' while cpu_reset_ already 1: unreachable, because RUN rejects it with err.
- err is sticky until reset. It never blocks subsequent valid frames.

Optional Feature:
- Macro: MEM_LOADER_CHECKSUM_EN.
- When defined:
  - Every load frame with LEN>0 carries one trailing checksum byte, consumed in CSUM.
  - Frame is valid when (sum of payload bytes + checksum) mod 256 = 0.
  - Mismatch sets err. Payload writes already issued are not undone.
  - LEN=0 frames carry no checksum byte.
- When undefined: there is no CSUM state, and the byte after the last payload byte is decoded as a new command.

Test Plan:
- Reset: hold reset_=0 for 3 cycles → cpu_reset_=0, i_wr=d_wr=0, err=0, s_ready=0. s_ready=1 on the first cycle after release.
- Imem load: stream 49 00 10 00 03 AA BB CC at full rate → i_wr pulses at addr 0x010/0x011/0x012 with data AA/BB/CC on 3 consecutive cycles; d_wr never set; busy falls after CC.
- Dmem load with bubbles and wrap: stream 44 0F FF 00 02 11 22, with s_valid low 2 cycles between payload bytes → d_wr at 0xFFF=11, then at 0x000=22; no strobes during gaps.
- GO and halt with COOL_OFF=4: send 47 → s_ready=0 for the cool-off window; cpu_reset_ rises exactly 5 cycles after accept. Then send 52 → cpu_reset_=0 next cycle; state IDLE.
- Error handling: send 7E in IDLE → err=1, no writes. A following valid 'I' frame writes normally. Sending 49 in RUN → err stays 1 and cpu_reset_ stays 1.
- With MEM_LOADER_CHECKSUM_EN: 49 00 00 00 02 01 02 FD → writes done, err=0. Resend with checksum FE → writes done, err=1.
